// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and key mailbox.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] KEY_UP         = 8'h75;
    localparam logic [7:0] KEY_DOWN       = 8'h72;
    localparam logic [7:0] KEY_ENTER      = 8'h5A;

    // Odd parity holds when the 8 data bits plus the parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronisers, ps2_clk glitch filter, frame FSM and timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       frame_err,
    output logic       par_fail,
    output logic [1:0] state_dbg
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          clk_filt, clk_filt_q;
    logic [FW-1:0] flt_cnt;
    logic          fall;

    frame_state_t  state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          par_bit, par_n;
    logic [TW-1:0] timer, timer_n;
    logic          stb_n, err_n, pfail_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            data_s1    <= 1'b1;
            data_s2    <= 1'b1;
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
            flt_cnt    <= '0;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            data_s1    <= ps2_data;
            data_s2    <= data_s1;
            clk_filt_q <= clk_filt;
            // The filtered clock follows only after FILTER_LEN consecutive differing samples.
            if (clk_s2 == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    assign fall = clk_filt_q & ~clk_filt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            timer     <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            par_fail  <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            par_bit   <= par_n;
            timer     <= timer_n;
            byte_stb  <= stb_n;
            frame_err <= err_n;
            par_fail  <= pfail_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_n     = par_bit;
        timer_n   = timer;
        stb_n     = 1'b0;
        err_n     = 1'b0;
        pfail_n   = 1'b0;
        if (fall) begin
            timer_n = '0;
            case (state)
                IDLE: begin
                    if (!data_s2) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shift_n   = {data_s2, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = data_s2;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!data_s2) begin
                        err_n = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    end else if (!odd_parity_ok(shift, par_bit)) begin
                        err_n   = 1'b1;
                        pfail_n = 1'b1;
`endif
                    end else begin
                        stb_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                err_n   = 1'b1;
                state_n = IDLE;
                timer_n = '0;
            end else begin
                timer_n = timer + TW'(1);
            end
        end else begin
            timer_n = '0;
        end
    end

`ifndef PS2_PARITY_CHECK_EN
    logic unused_par;
    assign unused_par = par_bit;
`endif

    // byte_stb is a one-cycle valid with no ready: rx_byte is stable on the strobe and until the next start bit.
    assign rx_byte   = shift;
    assign state_dbg = state;

endmodule

// File: rtl/ps2_key_mailbox.sv
// PS/2 key mailbox: make/break/extended decode into a CPU-readable held-key register at word KEY_ADDR.
// Build with PS2_PARITY_CHECK_EN defined to reject frames with bad odd parity.
module ps2_key_mailbox
    import ps2_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int KEY_ADDR       = 10,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_we,
    output logic              key_sel,
    output logic [31:0]       key_rdata,
    output logic              key_ext,
    output logic              key_valid,
    output logic              frame_err,
    output logic [1:0]        dbg_state
);

    logic [7:0] rx_byte;
    logic       byte_stb, par_fail;

    logic [7:0] key_code, code_n;
    logic       ext_n, ext_p, extp_n, brk_p, brkp_n, valid_n;
    logic       hw_upd, cpu_clr;

    ps2_rx_frame #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .byte_stb (byte_stb),
        .frame_err(frame_err),
        .par_fail (par_fail),
        .state_dbg(dbg_state)
    );

    assign key_sel   = (mem_addr == ADDR_W'(KEY_ADDR));
    assign cpu_clr   = mem_we & key_sel;
    assign key_rdata = {24'd0, key_code};

    always_comb begin
        code_n  = key_code;
        ext_n   = key_ext;
        extp_n  = ext_p;
        brkp_n  = brk_p;
        valid_n = 1'b0;
        hw_upd  = 1'b0;
        if (byte_stb) begin
            if (rx_byte == PS2_PREFIX_EXT) begin
                extp_n = 1'b1;
            end else if (rx_byte == PS2_PREFIX_BRK) begin
                brkp_n = 1'b1;
            end else begin
                extp_n = 1'b0;
                brkp_n = 1'b0;
                if (!brk_p) begin
                    code_n  = rx_byte;
                    ext_n   = ext_p;
                    valid_n = 1'b1;
                    hw_upd  = 1'b1;
                end else if (rx_byte == key_code && ext_p == key_ext) begin
                    // A break only releases the key that is actually held.
                    code_n  = 8'd0;
                    ext_n   = 1'b0;
                    valid_n = 1'b1;
                    hw_upd  = 1'b1;
                end
            end
        end
        if (par_fail) begin
            extp_n = 1'b0;
            brkp_n = 1'b0;
        end
        if (cpu_clr && !hw_upd) begin
            code_n = 8'd0;
            ext_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_code  <= 8'd0;
            key_ext   <= 1'b0;
            ext_p     <= 1'b0;
            brk_p     <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            key_code  <= code_n;
            key_ext   <= ext_n;
            ext_p     <= extp_n;
            brk_p     <= brkp_n;
            key_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_ps2_key_mailbox.sv
// Directed bench for ps2_key_mailbox: PS/2 frames at 12.5 kHz against a 1 MHz system clock.
`timescale 1ns/1ps
module tb_ps2_key_mailbox;
    import ps2_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk, ps2_data;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic        key_sel, key_ext, key_valid, frame_err;
    logic [31:0] key_rdata;
    logic [1:0]  dbg_state;

    int n_pass = 0, n_checks = 0, n_fail = 0;
    int valid_cnt = 0, err_cnt = 0;
    int v0, e0;
    bit hit;

    ps2_key_mailbox dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .key_sel  (key_sel),
        .key_rdata(key_rdata),
        .key_ext  (key_ext),
        .key_valid(key_valid),
        .frame_err(frame_err),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #500 clk = ~clk;

    always @(posedge clk) begin
        if (key_valid) valid_cnt <= valid_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver: one PS/2 bit, data changes mid-high, 40 us half periods
    task automatic ps2_bit(input logic b);
        #20000 ps2_data = b;
        #20000 ps2_clk  = 1'b0;
        #40000 ps2_clk  = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip_par, input logic bad_stop);
        logic par;
        par = ~(^b) ^ flip_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic bad_stop);
        send_bits(mk_frame(b, flip_par, bad_stop), 11);
        #20000 ps2_data = 1'b1;
        #20000;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic cpu_write(input logic [31:0] a);
        @(negedge clk);
        mem_addr = a;
        mem_we   = 1'b1;
        @(negedge clk);
        mem_we   = 1'b0;
        mem_addr = 32'd10;
    endtask

    initial begin
        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; mem_addr = 32'd0; mem_we = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_rdata", key_rdata, 32'h0);
        check("rst_ext", {31'd0, key_ext}, 32'd0);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("sel_other", {31'd0, key_sel}, 32'd0);
        mem_addr = 32'd10;
        #1;
        check("sel_key", {31'd0, key_sel}, 32'd1);
        #9999 rst = 1'b1;

        // 1: extended make of UP
        v0 = valid_cnt;
        send_byte(8'hE0);
        send_byte(8'h75);
        check("e0_75_rdata", key_rdata, 32'h75);
        check("e0_75_ext", {31'd0, key_ext}, 32'd1);
        check("e0_75_pulses", valid_cnt - v0, 32'd1);

        // 2: matching extended break, then a mismatched break
        v0 = valid_cnt;
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("brk_rdata", key_rdata, 32'h0);
        check("brk_ext", {31'd0, key_ext}, 32'd0);
        check("brk_pulses", valid_cnt - v0, 32'd1);
        send_byte(8'h75);
        check("make75_rdata", key_rdata, 32'h75);
        check("make75_ext", {31'd0, key_ext}, 32'd0);
        v0 = valid_cnt;
        send_byte(8'hF0);
        send_byte(8'h72);
        check("brk72_keeps", key_rdata, 32'h75);
        check("brk72_pulses", valid_cnt - v0, 32'd0);

        // 3: CPU acknowledge, write to another word, collision with a make
        send_byte(8'h5A);
        check("make5a", key_rdata, 32'h5A);
        cpu_write(32'd10);
        check("cpu_clear", key_rdata, 32'h0);
        send_byte(8'h5A);
        cpu_write(32'd11);
        check("cpu_other_addr", key_rdata, 32'h5A);
        v0 = valid_cnt;
        hit = 1'b0;
        fork
            send_byte(8'h72);
            begin
                for (int i = 0; i < 1500 && !hit; i++) begin
                    @(negedge clk);
                    if (dut.u_rx.byte_stb) begin
                        mem_we = 1'b1;
                        @(negedge clk);
                        mem_we = 1'b0;
                        hit = 1'b1;
                    end
                end
            end
        join
        check("collision_seen", {31'd0, hit}, 32'd1);
        check("collision_make_wins", key_rdata, 32'h72);
        send_byte(8'h72);
        check("typematic_rdata", key_rdata, 32'h72);
        check("typematic_pulses", valid_cnt - v0, 32'd2);

        // 4: bad stop, timeout, glitch, then a clean frame
        e0 = err_cnt;
        send_frame(8'h33, 1'b0, 1'b1);
        check("stop_err", err_cnt - e0, 32'd1);
        check("stop_state", {30'd0, dbg_state}, 32'd0);
        check("stop_dropped", key_rdata, 32'h72);
        e0 = err_cnt;
        send_bits(mk_frame(8'h55, 1'b0, 1'b0), 4);
        check("partial_state", {30'd0, dbg_state}, {30'd0, DATA});
        #6000000;
        ps2_data = 1'b1;
        check("timeout_err", err_cnt - e0, 32'd1);
        check("timeout_state", {30'd0, dbg_state}, 32'd0);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        #2000 ps2_clk = 1'b1;
        #20000 ps2_data = 1'b1;
        #20000;
        check("glitch_ignored", {30'd0, dbg_state}, 32'd0);
        send_byte(8'h1C);
        check("after_err_1c", key_rdata, 32'h1C);

        // 5: flipped parity on an UP make
        cpu_write(32'd10);
        check("pre_par_clear", key_rdata, 32'h0);
        e0 = err_cnt;
        send_frame(8'h75, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err", err_cnt - e0, 32'd1);
        check("par_rdata", key_rdata, 32'h0);
`else
        check("par_err", err_cnt - e0, 32'd0);
        check("par_rdata", key_rdata, 32'h75);
`endif

        // 6: reset in the middle of a frame
        send_byte(8'hE0);
        send_byte(8'h1C);
        check("ext1c_rdata", key_rdata, 32'h1C);
        check("ext1c_ext", {31'd0, key_ext}, 32'd1);
        send_bits(mk_frame(8'h29, 1'b0, 1'b0), 5);
        check("mid_state", {30'd0, dbg_state}, {30'd0, DATA});
        #100 rst = 1'b0;
        #100;
        check("midrst_rdata", key_rdata, 32'h0);
        check("midrst_ext", {31'd0, key_ext}, 32'd0);
        check("midrst_valid", {31'd0, key_valid}, 32'd0);
        check("midrst_err", {31'd0, frame_err}, 32'd0);
        check("midrst_state", {30'd0, dbg_state}, 32'd0);
        #800 rst = 1'b1;
        ps2_data = 1'b1;
        send_byte(8'h29);
        check("post_rst_29", key_rdata, 32'h29);
        check("post_rst_ext", {31'd0, key_ext}, 32'd0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
